alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/clock_pkg.sv | 20 ++
 rtl/alarm_time_add.sv | 27 ++
 rtl/alarm_ctrl.sv | 151 +++++++++++++++
 tb/tb_alarm_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day constants, alarm FSM state encoding and a wrap-around
// increment helper, common to the clock counter and the alarm controller.
package clock_pkg;

  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_HOUR = 6'd23;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max_val);
    return (val >= max_val) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_time_add.sv
// Combinational hour:minute + ADD_MIN adder; minutes carry into hours and
// hours wrap past 23 back to 0.
module alarm_time_add
  import clock_pkg::*;
#(
  parameter int unsigned ADD_MIN = 5
) (
  input  logic [5:0] in_hour,
  input  logic [5:0] in_min,
  output logic [5:0] out_hour,
  output logic [5:0] out_min
);

  logic [6:0] min_sum;

  always_comb begin
    min_sum = {1'b0, in_min} + 7'(ADD_MIN);
    if (min_sum > {1'b0, MAX_MIN}) begin
      out_min  = 6'(min_sum - 7'd60);
      out_hour = wrap_inc(in_hour, MAX_HOUR);
    end else begin
      out_min  = min_sum[5:0];
      out_hour = in_hour;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm-clock controller: stores the alarm time, arms/disarms, rings with a
// 0.5 Hz beep, snoozes by SNOOZE_MIN minutes and auto-silences after RING_SECS.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       sec_tick,
  input  logic [5:0] count_sec,
  input  logic [5:0] count_min,
  input  logic [5:0] count_hour,
  input  logic       arm_tgl,
  input  logic       set_min_inc,
  input  logic       set_hour_inc,
  input  logic       snooze,
  input  logic       stop,
  output logic [5:0] alarm_min,
  output logic [5:0] alarm_hour,
  output logic       armed,
  output logic       ringing,
  output logic       buzzer,
  output logic       snoozing
);

  localparam logic [5:0] RING_LAST = 6'(RING_SECS - 1);

  alarm_state_t state;
  logic [5:0]   ring_cnt;
  logic [5:0]   snz_hour;
  logic [5:0]   snz_min;
  logic [5:0]   tgt_hour;
  logic [5:0]   tgt_min;
  logic         alarm_match;
  logic         snooze_match;

  alarm_time_add #(.ADD_MIN(SNOOZE_MIN)) u_snooze_add (
    .in_hour  (count_hour),
    .in_min   (count_min),
    .out_hour (tgt_hour),
    .out_min  (tgt_min)
  );

  assign alarm_match  = sec_tick && (count_sec == 6'd0) &&
                        (count_hour == alarm_hour) && (count_min == alarm_min);
  assign snooze_match = sec_tick && (count_sec == 6'd0) &&
                        (count_hour == snz_hour) && (count_min == snz_min);

  // Alarm time setting is independent of the FSM and accepted in every state
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      alarm_min  <= 6'd0;
      alarm_hour <= 6'd0;
    end else begin
      if (set_min_inc) begin
        alarm_min <= wrap_inc(alarm_min, MAX_MIN);
      end
      if (set_hour_inc) begin
        alarm_hour <= wrap_inc(alarm_hour, MAX_HOUR);
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state    <= ST_OFF;
      ring_cnt <= 6'd0;
      snz_hour <= 6'd0;
      snz_min  <= 6'd0;
      armed    <= 1'b0;
      ringing  <= 1'b0;
      buzzer   <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (arm_tgl) begin
            state <= ST_ARMED;
            armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (arm_tgl) begin
            state <= ST_OFF;
            armed <= 1'b0;
          end else if (alarm_match) begin
            state    <= ST_RINGING;
            ring_cnt <= 6'd0;
            ringing  <= 1'b1;
            buzzer   <= 1'b1;
          end
        end
        ST_RINGING: begin
          // arm_tgl > stop > snooze > ring timeout
          if (arm_tgl) begin
            state   <= ST_OFF;
            armed   <= 1'b0;
            ringing <= 1'b0;
            buzzer  <= 1'b0;
          end else if (stop) begin
            state   <= ST_ARMED;
            ringing <= 1'b0;
            buzzer  <= 1'b0;
          end else if (snooze) begin
            state    <= ST_SNOOZE;
            snz_hour <= tgt_hour;
            snz_min  <= tgt_min;
            ringing  <= 1'b0;
            buzzer   <= 1'b0;
            snoozing <= 1'b1;
          end else if (sec_tick) begin
            ring_cnt <= ring_cnt + 6'd1;
            if (ring_cnt == RING_LAST) begin
              state   <= ST_ARMED;
              ringing <= 1'b0;
              buzzer  <= 1'b0;
            end else begin
              buzzer <= ~buzzer;
            end
          end
        end
        ST_SNOOZE: begin
          if (arm_tgl) begin
            state    <= ST_OFF;
            armed    <= 1'b0;
            snoozing <= 1'b0;
          end else if (stop) begin
            state    <= ST_ARMED;
            snoozing <= 1'b0;
          end else if (snooze_match) begin
            state    <= ST_RINGING;
            ring_cnt <= 6'd0;
            ringing  <= 1'b1;
            buzzer   <= 1'b1;
            snoozing <= 1'b0;
          end
        end
        default: begin
          state    <= ST_OFF;
          armed    <= 1'b0;
          ringing  <= 1'b0;
          buzzer   <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: expectations are queued with each stimulus
// and compared against the DUT outputs one clock later (sampled on negedge).
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       sec_tick = 1'b0;
  logic [5:0] count_sec = 6'd0;
  logic [5:0] count_min = 6'd0;
  logic [5:0] count_hour = 6'd0;
  logic       arm_tgl = 1'b0;
  logic       set_min_inc = 1'b0;
  logic       set_hour_inc = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic [5:0] alarm_min;
  logic [5:0] alarm_hour;
  logic       armed;
  logic       ringing;
  logic       buzzer;
  logic       snoozing;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [5:0] e_h = 6'd0;
  logic [5:0] e_m = 6'd0;

  alarm_ctrl dut (
    .clk          (clk),
    .RESET        (RESET),
    .sec_tick     (sec_tick),
    .count_sec    (count_sec),
    .count_min    (count_min),
    .count_hour   (count_hour),
    .arm_tgl      (arm_tgl),
    .set_min_inc  (set_min_inc),
    .set_hour_inc (set_hour_inc),
    .snooze       (snooze),
    .stop         (stop),
    .alarm_min    (alarm_min),
    .alarm_hour   (alarm_hour),
    .armed        (armed),
    .ringing      (ringing),
    .buzzer       (buzzer),
    .snoozing     (snoozing)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Expected vector layout: {hour, min, armed, ringing, buzzer, snoozing}
  task automatic push_exp(input string tag, input logic a, input logic r, input logic b, input logic s);
    exp_t e;
    e.tag = tag;
    e.val = {e_h, e_m, a, r, b, s};
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, {alarm_hour, alarm_min, armed, ringing, buzzer, snoozing}, e.val);
    end
  endtask

  task automatic pulse(input logic a, input logic mi, input logic hi, input logic sn, input logic st);
    @(negedge clk);
    arm_tgl = a; set_min_inc = mi; set_hour_inc = hi; snooze = sn; stop = st;
    @(negedge clk);
    arm_tgl = 1'b0; set_min_inc = 1'b0; set_hour_inc = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic tick(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    @(negedge clk);
    count_hour = h; count_min = m; count_sec = s; sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  task automatic inc_hour(input int n);
    for (int i = 0; i < n; i++) begin
      e_h = (e_h == 6'd23) ? 6'd0 : e_h + 6'd1;
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic inc_min(input int n);
    for (int i = 0; i < n; i++) begin
      e_m = (e_m == 6'd59) ? 6'd0 : e_m + 6'd1;
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    push_exp("reset_state", 1'b0, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    RESET = 1'b0;

    // Program 07:30 and arm
    inc_hour(7);
    inc_min(30);
    push_exp("set_0730", 1'b0, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    push_exp("arm", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    push_exp("no_match_072959", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(6'd7, 6'd29, 6'd59);
    pop_cmp();
    push_exp("ring_073000", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(6'd7, 6'd30, 6'd0);
    pop_cmp();

    // Beep toggles each tick, auto-silence after RING_SECS ticks
    for (int i = 1; i <= 60; i++) begin
      if (i < 60) begin
        push_exp($sformatf("ring_tick%0d", i), 1'b1, 1'b1, (i % 2 == 0), 1'b0);
        tick(6'd7, 6'd30, 6'(i));
      end else begin
        push_exp("ring_timeout", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(6'd7, 6'd31, 6'd0);
      end
      pop_cmp();
      repeat (2) @(negedge clk);
    end

    // Wrap boundaries
    inc_hour(16);
    push_exp("hour_23", 1'b1, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    inc_hour(1);
    push_exp("hour_wrap_0", 1'b1, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    inc_hour(23);
    inc_min(29);
    push_exp("min_59", 1'b1, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    inc_min(1);
    push_exp("min_wrap_no_carry", 1'b1, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    inc_min(58);

    // Ring at 23:58, snooze to 00:03 across midnight
    push_exp("ring_2358", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(6'd23, 6'd58, 6'd0);
    pop_cmp();
    push_exp("snooze_entry", 1'b1, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pop_cmp();
    push_exp("snooze_000200", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(6'd0, 6'd2, 6'd0);
    pop_cmp();
    inc_min(1);
    push_exp("set_during_snooze", 1'b1, 1'b0, 1'b0, 1'b1);
    pop_cmp();
    push_exp("snooze_ring_000300", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(6'd0, 6'd3, 6'd0);
    pop_cmp();

    push_exp("arm_beats_stop", 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_cmp();

    // Stop from RINGING and from SNOOZE, alarm now 23:59
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("ring_2359", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(6'd23, 6'd59, 6'd0);
    pop_cmp();
    push_exp("stop_ringing", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_cmp();
    tick(6'd23, 6'd59, 6'd0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp("stop_snooze", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_cmp();
    push_exp("ring_again", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(6'd23, 6'd59, 6'd0);
    pop_cmp();

    // Asynchronous reset between clock edges while ringing
    @(negedge clk);
    #3;
    RESET = 1'b1;
    #1;
    e_h = 6'd0;
    e_m = 6'd0;
    push_exp("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    @(negedge clk);
    RESET = 1'b0;
    push_exp("no_ring_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(6'd0, 6'd0, 6'd0);
    pop_cmp();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("ring_after_rearm", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(6'd0, 6'd0, 6'd0);
    pop_cmp();

    check_val("sb_empty", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
